cache_miss_ctrl: RTL

//  Sequencing controller for the set-associative cache storage arrays. It accepts one CPU

---
 rtl/cache_pkg.sv | 36 +++
 rtl/cache_repl.sv | 79 +++++++
 rtl/cache_miss_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache miss controller slice.
// CACHE_CTRL_PLRU_EN selects tree pseudo-LRU replacement (default: round-robin).
package cache_pkg;

  localparam int ADDR_W     = 16;
  localparam int INDEX_W    = 4;
  localparam int WAYS       = 4;
  localparam int LINE_BEATS = 4;
  localparam int BEAT_BYTES = 4;

  localparam int WAY_W    = $clog2(WAYS);
  localparam int BEAT_W   = $clog2(LINE_BEATS);
  localparam int OFFSET_W = BEAT_W + $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
  } cpu_req_t;

  function automatic logic [WAYS-1:0] way_onehot(
    input logic [WAY_W-1:0] w
  );
    way_onehot    = '0;
    way_onehot[w] = 1'b1;
  endfunction

endpackage

// File: rtl/cache_repl.sv
// Victim selection: per-set tree PLRU when CACHE_CTRL_PLRU_EN is
// defined, otherwise one global round-robin pointer.
module cache_repl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [WAY_W-1:0]   access_way,
  input  logic               update,
  input  logic               refill,
  output logic [WAY_W-1:0]   victim_way
);

`ifdef CACHE_CTRL_PLRU_EN
  localparam int SETS = 2 ** INDEX_W;

  logic [WAYS-2:0] tree_q [SETS];
  logic [WAYS-2:0] row_d;
  logic [WAYS-2:0] row;
  logic            unused_refill;

  assign row           = tree_q[index];
  assign unused_refill = refill;

  // Heap-ordered tree: node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
  always_comb begin
    int node;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      node = 2 * node + 1 + int'(row[node]);
    end
    victim_way = WAY_W'(node - (WAYS - 1));
  end

  always_comb begin
    int node;
    row_d = row;
    node  = 0;
    for (int l = 0; l < WAY_W; l++) begin
      row_d[node] = ~access_way[WAY_W-1-l];
      node = 2 * node + 1 + int'(access_way[WAY_W-1-l]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s] <= '0;
      end
    end else if (update) begin
      tree_q[index] <= row_d;
    end
  end
`else
  logic [WAY_W-1:0] ptr_q;
  logic [WAY_W-1:0] ptr_d;
  logic             unused_sel;

  assign unused_sel = ^{index, access_way};
  assign victim_way = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (update && refill) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache request sequencer: hit handling, victim refill, array strobes.
// Replacement policy chosen by CACHE_CTRL_PLRU_EN (see cache_repl).
module cache_miss_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req_valid,
  output logic               cpu_req_ready,
  input  logic [ADDR_W-1:0]  cpu_req_addr,
  input  logic               cpu_req_write,
  output logic               cpu_resp_valid,
  input  logic               tag_hit,
  input  logic [WAY_W-1:0]   tag_hit_way,
  output logic [INDEX_W-1:0] arr_index,
  output logic [WAYS-1:0]    arr_way_dec,
  output logic               arr_mem_write,
  output logic               arr_miss,
  output logic [BEAT_W-1:0]  arr_beat,
  output logic               arr_tag_write,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rdata_valid,
  output logic               busy
);

  state_e             state_q, state_d;
  cpu_req_t           req_q, req_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [WAYS-1:0]    dec_q, dec_d;

  logic               repl_upd;
  logic               repl_fill;
  logic [WAY_W-1:0]   repl_way;
  logic [WAY_W-1:0]   victim;
  logic               last_beat;
  logic               unused_offset;

  assign last_beat     = beat_q == BEAT_W'(LINE_BEATS - 1);
  assign unused_offset = ^req_q.addr[OFFSET_W-1:0];

  cache_repl u_repl (
    .clk        (clk),
    .reset      (reset),
    .index      (index_q),
    .access_way (repl_way),
    .update     (repl_upd),
    .refill     (repl_fill),
    .victim_way (victim)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    way_d     = way_q;
    beat_d    = beat_q;
    index_d   = index_q;
    dec_d     = dec_q;
    repl_upd  = 1'b0;
    repl_fill = 1'b0;
    repl_way  = way_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          req_d   = '{addr: cpu_req_addr, write: cpu_req_write};
          index_d = cpu_req_addr[OFFSET_W +: INDEX_W];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (tag_hit) begin
          way_d    = tag_hit_way;
          dec_d    = way_onehot(tag_hit_way);
          repl_upd = 1'b1;
          repl_way = tag_hit_way;
          state_d  = req_q.write ? S_WRITE : S_RESP;
        end else begin
          way_d   = victim;
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (mem_req_ready) begin
          dec_d   = way_onehot(way_q);
          beat_d  = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_rdata_valid) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            repl_upd  = 1'b1;
            repl_fill = 1'b1;
            state_d   = req_q.write ? S_WRITE : S_RESP;
          end
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        dec_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      way_q   <= '0;
      beat_q  <= '0;
      index_q <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      way_q   <= way_d;
      beat_q  <= beat_d;
      index_q <= index_d;
      dec_q   <= dec_d;
    end
  end

  assign cpu_req_ready  = state_q == S_IDLE;
  assign busy           = state_q != S_IDLE;
  assign cpu_resp_valid = state_q == S_RESP;
  assign arr_mem_write  = state_q == S_WRITE;
  assign mem_req_valid  = state_q == S_MISS_REQ;
  assign mem_req_addr   = {req_q.addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign arr_index      = index_q;
  assign arr_way_dec    = dec_q;
  assign arr_beat       = beat_q;
  assign arr_miss       = (state_q == S_REFILL) && mem_rdata_valid;
  assign arr_tag_write  = arr_miss && last_beat;

endmodule
